// File: rtl/mdio_responder.sv
`timescale 1ns/1ps
// MDIO management-frame responder: decodes station frames clocked by an asynchronous
// MDC, issues one-clk register strobes and drives read data back onto the MDIO line.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         PRE_MIN  = 32,
    parameter int         TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_en,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        frame_err
);

    localparam int PW = $clog2(PRE_MIN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_MIN);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_HIT  = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_HUNT, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    logic [1:0]    mdc_sync_r, mdio_sync_r;
    logic          mdc_prev_r;
    logic          rise_s, fall_s, bit_s, timeout_s;
    logic [TW-1:0] to_cnt_r;
    state_t        state_r, state_nx;
    logic [PW-1:0] ones_r, ones_nx;
    logic [4:0]    bit_cnt_r, bit_cnt_nx;
    logic [4:0]    fld_r, fld_nx;
    logic          is_read_r, is_read_nx;
    logic [4:0]    addr_nx;
    logic [15:0]   wdata_nx;
    logic          err_s, rd_go_s, we_go_s;
    logic [1:0]    rd_pipe_r;
    logic [15:0]   tx_r, tx_nx;
    logic          mdio_out_nx, mdio_en_nx;

    assign rise_s    = mdc_sync_r[1] & ~mdc_prev_r;
    assign fall_s    = ~mdc_sync_r[1] & mdc_prev_r;
    assign bit_s     = mdio_sync_r[1];
    assign timeout_s = ~(rise_s | fall_s) & (to_cnt_r == TO_HIT);

    // Two-flop synchronizers for MDC/MDIO plus MDC edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdc_sync_r  <= 2'b00;
            mdio_sync_r <= 2'b00;
            mdc_prev_r  <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[0], mdc};
            mdio_sync_r <= {mdio_sync_r[0], mdio_in};
            mdc_prev_r  <= mdc_sync_r[1];
        end
    end

    // Idle-MDC watchdog, saturating so a stalled bus yields a single timeout event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (rise_s | fall_s) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Frame state register and receive datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_HUNT;
            ones_r    <= {PW{1'b0}};
            bit_cnt_r <= 5'd0;
            fld_r     <= 5'd0;
            is_read_r <= 1'b0;
            reg_addr  <= 5'd0;
            reg_wdata <= 16'd0;
        end else begin
            state_r   <= state_nx;
            ones_r    <= ones_nx;
            bit_cnt_r <= bit_cnt_nx;
            fld_r     <= fld_nx;
            is_read_r <= is_read_nx;
            reg_addr  <= addr_nx;
            reg_wdata <= wdata_nx;
        end
    end

    // Next-state decode: bits are consumed on MDC rises, read turnaround/data advance on falls
    always_comb begin
        state_nx   = state_r;
        ones_nx    = ones_r;
        bit_cnt_nx = bit_cnt_r;
        fld_nx     = fld_r;
        is_read_nx = is_read_r;
        addr_nx    = reg_addr;
        wdata_nx   = reg_wdata;
        err_s      = 1'b0;
        rd_go_s    = 1'b0;
        we_go_s    = 1'b0;
        if (timeout_s) begin
            ones_nx  = {PW{1'b0}};
            state_nx = S_HUNT;
            err_s    = (state_r != S_HUNT);
        end else if (rise_s) begin
            case (state_r)
                S_HUNT: begin
                    if (bit_s) begin
                        ones_nx = (ones_r == PRE_MAX) ? ones_r : ones_r + PW'(1);
                    end else if (ones_r == PRE_MAX) begin
                        state_nx = S_ST;
                        ones_nx  = {PW{1'b0}};
                    end else begin
                        ones_nx = {PW{1'b0}};
                    end
                end
                S_ST: begin
                    if (bit_s) begin
                        state_nx   = S_OP;
                        bit_cnt_nx = 5'd0;
                    end else begin
                        state_nx = S_HUNT;
                        err_s    = 1'b1;
                    end
                end
                S_OP: begin
                    fld_nx = {fld_r[3:0], bit_s};
                    if (bit_cnt_r == 5'd0) begin
                        bit_cnt_nx = 5'd1;
                    end else begin
                        bit_cnt_nx = 5'd0;
                        case ({fld_r[0], bit_s})
                            2'b10: begin state_nx = S_PHYAD; is_read_nx = 1'b1; end
                            2'b01: begin state_nx = S_PHYAD; is_read_nx = 1'b0; end
                            default: begin
                                state_nx   = S_SKIP;
                                bit_cnt_nx = 5'd17;
                                err_s      = 1'b1;
                            end
                        endcase
                    end
                end
                S_PHYAD: begin
                    fld_nx     = {fld_r[3:0], bit_s};
                    bit_cnt_nx = (bit_cnt_r == 5'd4) ? 5'd0 : bit_cnt_r + 5'd1;
                    state_nx   = (bit_cnt_r == 5'd4) ? S_REGAD : S_PHYAD;
                end
                S_REGAD: begin
                    addr_nx = {reg_addr[3:0], bit_s};
                    if (bit_cnt_r != 5'd4) begin
                        bit_cnt_nx = bit_cnt_r + 5'd1;
                    end else if (fld_r == PHY_ADDR) begin
                        state_nx   = S_TA;
                        bit_cnt_nx = 5'd0;
                        rd_go_s    = is_read_r;
                    end else begin
                        state_nx   = S_SKIP;
                        bit_cnt_nx = 5'd17;
                    end
                end
                S_TA: begin
                    if (is_read_r) begin
                        bit_cnt_nx = bit_cnt_r;
                    end else if (bit_cnt_r == 5'd0) begin
                        fld_nx     = {fld_r[3:0], bit_s};
                        bit_cnt_nx = 5'd1;
                    end else if ({fld_r[0], bit_s} == 2'b10) begin
                        state_nx   = S_WDATA;
                        bit_cnt_nx = 5'd0;
                    end else begin
                        state_nx   = S_SKIP;
                        bit_cnt_nx = 5'd15;
                        err_s      = 1'b1;
                    end
                end
                S_WDATA: begin
                    wdata_nx   = {reg_wdata[14:0], bit_s};
                    bit_cnt_nx = bit_cnt_r + 5'd1;
                    state_nx   = (bit_cnt_r == 5'd15) ? S_HUNT : S_WDATA;
                    we_go_s    = (bit_cnt_r == 5'd15);
                end
                S_SKIP: begin
                    if (bit_cnt_r == 5'd0) begin
                        state_nx = S_HUNT;
                        ones_nx  = {PW{1'b0}};
                    end else begin
                        bit_cnt_nx = bit_cnt_r - 5'd1;
                    end
                end
                S_RDATA: state_nx = S_RDATA;
                default: state_nx = S_HUNT;
            endcase
        end else if (fall_s) begin
            case (state_r)
                S_TA: begin
                    if (!is_read_r) begin
                        bit_cnt_nx = bit_cnt_r;
                    end else if (bit_cnt_r == 5'd0) begin
                        bit_cnt_nx = 5'd1;
                    end else begin
                        state_nx   = S_RDATA;
                        bit_cnt_nx = 5'd0;
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_r == 5'd16) begin
                        state_nx = S_HUNT;
                    end else begin
                        bit_cnt_nx = bit_cnt_r + 5'd1;
                    end
                end
                default: state_nx = state_r;
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Output next values: line drive only in read TA/RDATA, updated after detected falls
    always_comb begin
        mdio_out_nx = mdio_out;
        mdio_en_nx  = mdio_en;
        if (rd_pipe_r[1]) begin
            tx_nx = reg_rdata;
        end else if (fall_s && (state_r == S_RDATA) && (bit_cnt_r != 5'd16)) begin
            tx_nx = {tx_r[14:0], 1'b0};
        end else begin
            tx_nx = tx_r;
        end
        if (timeout_s) begin
            mdio_out_nx = 1'b0;
            mdio_en_nx  = 1'b0;
        end else if (fall_s) begin
            case (state_r)
                S_TA: begin
                    mdio_out_nx = 1'b0;
                    mdio_en_nx  = is_read_r && (bit_cnt_r == 5'd1);
                end
                S_RDATA: begin
                    mdio_out_nx = (bit_cnt_r == 5'd16) ? 1'b0 : tx_r[15];
                    mdio_en_nx  = (bit_cnt_r != 5'd16);
                end
                default: begin
                    mdio_out_nx = 1'b0;
                    mdio_en_nx  = 1'b0;
                end
            endcase
        end else begin
            mdio_en_nx = mdio_en;
        end
    end

    // Registered outputs, strobes and read-data transmit shifter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdio_out  <= 1'b0;
            mdio_en   <= 1'b0;
            reg_rd    <= 1'b0;
            reg_we    <= 1'b0;
            frame_err <= 1'b0;
            rd_pipe_r <= 2'b00;
            tx_r      <= 16'd0;
        end else begin
            mdio_out  <= mdio_out_nx;
            mdio_en   <= mdio_en_nx;
            reg_rd    <= rd_go_s;
            reg_we    <= we_go_s;
            frame_err <= err_s;
            rd_pipe_r <= {rd_pipe_r[0], reg_rd};
            tx_r      <= tx_nx;
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
`timescale 1ns/1ps
// Directed bench for mdio_responder: a bit-level MDIO station with a pulled-up shared
// line, a register-file stub answering reads in a two-clk window, and pulse counters.
module tb_mdio_responder;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst_n, mdc, sta_oe, sta_bit;
    wire         mdio_line;
    logic        mdio_out, mdio_en, reg_rd, reg_we, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_rdata, reg_wdata, rdata_val;
    logic        rd_d1, rd_d2;
    logic [17:0] rx, ens;
    int half = 96;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_rd = 0, n_we = 0, n_err = 0, n_en = 0, n_cont = 0;
    int b_rd, b_we, b_err, b_en;

    mdio_responder #(.PHY_ADDR(5'd1), .PRE_MIN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_line),
        .mdio_out(mdio_out), .mdio_en(mdio_en), .reg_addr(reg_addr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign mdio_line = mdio_en ? mdio_out : (sta_oe ? sta_bit : 1'b1);
    // Read data is only valid in the cycle two clocks after the strobe
    assign reg_rdata = rd_d2 ? rdata_val : ~rdata_val;

    always @(posedge clk) begin
        rd_d1 <= reg_rd;
        rd_d2 <= rd_d1;
    end

    always @(negedge clk) begin
        if (reg_rd === 1'b1) n_rd++;
        if (reg_we === 1'b1) n_we++;
        if (frame_err === 1'b1) n_err++;
        if (mdio_en === 1'b1) n_en++;
        if (mdio_en === 1'b1 && sta_oe) n_cont++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rd = n_rd; b_we = n_we; b_err = n_err; b_en = n_en;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // One MDC period: station sets the line while MDC is low, samples it at the rise
    task automatic mbit(input logic drv, input logic b, output logic smp, output logic en);
        sta_oe  = drv;
        sta_bit = b;
        repeat (half) @(posedge clk);
        #1 mdc = 1'b1;
        smp = mdio_line;
        en  = mdio_en;
        repeat (half) @(posedge clk);
        #1 mdc = 1'b0;
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                         input bit rd, input int nd,
                         output logic [17:0] rxo, output logic [17:0] eno);
        logic s, e;
        rxo = 18'd0;
        eno = 18'd0;
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, s, e);
        mbit(1'b1, 1'b0, s, e);
        mbit(1'b1, 1'b1, s, e);
        for (int i = 1; i >= 0; i--) mbit(1'b1, op[i], s, e);
        for (int i = 4; i >= 0; i--) mbit(1'b1, phy[i], s, e);
        for (int i = 4; i >= 0; i--) mbit(1'b1, ra[i], s, e);
        if (rd) begin
            for (int i = 0; i < 2 + nd; i++) begin
                mbit(1'b0, 1'b1, s, e);
                rxo = {rxo[16:0], s};
                eno = {eno[16:0], e};
            end
        end else begin
            for (int i = 1; i >= 0; i--) mbit(1'b1, ta[i], s, e);
            for (int i = 15; i >= 0; i--) mbit(1'b1, wd[i], s, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; mdc = 1'b0; sta_oe = 1'b1; sta_bit = 1'b1; rdata_val = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mdio_en", {31'd0, mdio_en}, 32'd0);
        chk("rst_mdio_out", {31'd0, mdio_out}, 32'd0);
        chk("rst_strobes", {29'd0, reg_rd, reg_we, frame_err}, 32'd0);
        chk("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        chk("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
        rst_n = 1'b1;

        // Write reg 0x1F = 0xA5C3 at a slow MDC
        snap();
        frame(32, 2'b01, 5'd1, 5'h1F, 2'b10, 16'hA5C3, 1'b0, 0, rx, ens);
        idle(6);
        chk("wr_we_count", n_we - b_we, 32'd1);
        chk("wr_reg_addr", {27'd0, reg_addr}, 32'h1F);
        chk("wr_reg_wdata", {16'd0, reg_wdata}, 32'hA5C3);
        chk("wr_no_drive", n_en - b_en, 32'd0);
        chk("wr_no_rd_err", (n_rd - b_rd) + (n_err - b_err), 32'd0);

        // Read reg 0x02 = 0x1234
        half = 16;
        rdata_val = 16'h1234;
        snap();
        frame(32, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 1'b1, 16, rx, ens);
        idle(6);
        chk("rd_rd_count", n_rd - b_rd, 32'd1);
        chk("rd_station_data", {14'd0, rx}, 32'h21234);
        chk("rd_en_window", {14'd0, ens}, 32'h1FFFF);
        chk("rd_released", {31'd0, mdio_en}, 32'd0);
        chk("rd_reg_addr", {27'd0, reg_addr}, 32'h02);

        // Read to a foreign PHY, then a back-to-back write to this PHY
        snap();
        frame(32, 2'b10, 5'd3, 5'h05, 2'b00, 16'h0000, 1'b1, 16, rx, ens);
        chk("phy_miss_line", {14'd0, rx}, 32'h3FFFF);
        frame(32, 2'b01, 5'd1, 5'h0A, 2'b10, 16'h5A5A, 1'b0, 0, rx, ens);
        idle(6);
        chk("phy_miss_no_rd", n_rd - b_rd, 32'd0);
        chk("phy_miss_no_drive", n_en - b_en, 32'd0);
        chk("b2b_we_count", n_we - b_we, 32'd1);
        chk("b2b_reg_addr", {27'd0, reg_addr}, 32'h0A);
        chk("b2b_reg_wdata", {16'd0, reg_wdata}, 32'h5A5A);

        // Short preamble is ignored, a full one is decoded
        snap();
        frame(31, 2'b01, 5'd1, 5'h11, 2'b10, 16'h0F0E, 1'b0, 0, rx, ens);
        idle(6);
        chk("pre31_no_we", n_we - b_we, 32'd0);
        chk("pre31_wdata_held", {16'd0, reg_wdata}, 32'h5A5A);
        chk("pre31_addr_held", {27'd0, reg_addr}, 32'h0A);
        snap();
        frame(32, 2'b01, 5'd1, 5'h11, 2'b10, 16'h0F0E, 1'b0, 0, rx, ens);
        idle(6);
        chk("pre32_we_count", n_we - b_we, 32'd1);
        chk("pre32_reg_wdata", {16'd0, reg_wdata}, 32'h0F0E);
        chk("pre32_reg_addr", {27'd0, reg_addr}, 32'h11);

        // Bad write turnaround
        snap();
        frame(32, 2'b01, 5'd1, 5'h03, 2'b11, 16'h00FF, 1'b0, 0, rx, ens);
        idle(6);
        chk("ta11_err_count", n_err - b_err, 32'd1);
        chk("ta11_no_we", n_we - b_we, 32'd0);
        chk("ta11_wdata_held", {16'd0, reg_wdata}, 32'h0F0E);

        // MDC stalls in the middle of read data
        rdata_val = 16'hBEEF;
        snap();
        frame(32, 2'b10, 5'd1, 5'h04, 2'b00, 16'h0000, 1'b1, 5, rx, ens);
        idle(6);
        chk("to_partial_data", {14'd0, rx}, 32'h57);
        chk("to_driving", {31'd0, mdio_en}, 32'd1);
        idle(TO + 20);
        chk("to_released", {31'd0, mdio_en}, 32'd0);
        chk("to_err_count", n_err - b_err, 32'd1);

        // Reset in the middle of read data, then a complete read
        rdata_val = 16'h1357;
        frame(32, 2'b10, 5'd1, 5'h06, 2'b00, 16'h0000, 1'b1, 5, rx, ens);
        idle(6);
        chk("rst_mid_driving", {31'd0, mdio_en}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_released", {31'd0, mdio_en}, 32'd0);
        chk("rst_mid_addr", {27'd0, reg_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        frame(32, 2'b10, 5'd1, 5'h06, 2'b00, 16'h0000, 1'b1, 16, rx, ens);
        idle(6);
        chk("post_rst_rd_count", n_rd - b_rd, 32'd1);
        chk("post_rst_data", {14'd0, rx}, 32'h21357);
        chk("post_rst_en_window", {14'd0, ens}, 32'h1FFFF);
        chk("post_rst_released", {31'd0, mdio_en}, 32'd0);
        chk("post_rst_reg_addr", {27'd0, reg_addr}, 32'h06);
        chk("bus_contention", n_cont, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd0, the 5-bit PHY address this responder answers to.
REQ-002 SHALL have parameter PRE_MIN, default 32, the minimum count of consecutive preamble ones before ST is accepted.
REQ-003 SHALL have parameter TIMEOUT, default 4096, the number of clk cycles without an MDC edge that aborts a frame.
REQ-004 Port: clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-005 Port: rst_n, input, 1, synchronous active-low reset.
REQ-006 Port: mdc, input, 1, asynchronous management clock from the station.
REQ-007 Port: mdio_in, input, 1, asynchronous MDIO line value.
REQ-008 Port: mdio_out, output, 1, driven MDIO value.
REQ-009 Port: mdio_en, output, 1, output enable; 1 means this block drives MDIO.
REQ-010 Port: reg_addr, output, 5, REGAD of the current frame.
REQ-011 Port: reg_rd, output, 1, one-clk read strobe.
REQ-012 Port: reg_rdata, input, 16, read data, sampled exactly 2 clk after reg_rd.
REQ-013 Port: reg_wdata, output, 16, write data.
REQ-014 Port: reg_we, output, 1, one-clk write strobe.
REQ-015 Port: frame_err, output, 1, one-clk pulse on protocol error or timeout.

Function
REQ-016 mdc and mdio_in SHALL each pass through a 2-flop synchronizer. Rise/fall events SHALL be detected from the synchronized mdc against its previous value.
REQ-017 All MDIO bits SHALL be sampled from synchronized mdio on the clk where the mdc rise is detected. mdio_out/mdio_en SHALL change only on the clk following a detected mdc fall.
REQ-018 States: HUNT, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
REQ-019 HUNT: count consecutive sampled ones, saturating at PRE_MIN. A zero with count == PRE_MIN SHALL go to ST; a zero with count < PRE_MIN SHALL clear the count.
REQ-020 ST: the HUNT-terminating zero is ST bit 0. The next bit SHALL be 1, otherwise go to HUNT with frame_err.
REQ-021 OP: 2 bits MSB first. 10 = read, 01 = write. 00 or 11 SHALL go to SKIP(18) with frame_err.
REQ-022 PHYAD: 5 bits MSB first. REGAD: 5 bits MSB first, shifted into reg_addr.
REQ-023 If PHYAD != PHY_ADDR, the state SHALL go to SKIP(18) after REGAD, with no strobe and no drive.
REQ-024 On a matching read, reg_rd SHALL pulse on the clk after the last REGAD bit is sampled. reg_rdata SHALL be latched into the 16-bit transmit shifter 2 clk later.
REQ-025 Read TA: on the first mdc fall after REGAD, mdio_en SHALL stay 0.
REQ-026 Read TA: on the second mdc fall, mdio_en=1 and mdio_out=0.
REQ-027 RDATA: on each of the next 16 falls, drive data bits 15..0.
REQ-028 After the 16th data bit: on the next fall, mdio_en=0, then go to HUNT.
REQ-029 Write TA: 2 bits sampled. If the value is not 10, set frame_err and go to SKIP(16).
REQ-030 WDATA: 16 bits MSB first into reg_wdata. reg_we SHALL pulse on the clk after the 16th bit is sampled, then go to HUNT.
REQ-031 SKIP(n): ignore n sampled bits with no drive, then go to HUNT with the count cleared.
REQ-032 Timeout: a counter resets on every mdc edge. When it reaches TIMEOUT in any state other than HUNT: mdio_en=0, frame_err pulse, go to HUNT.
REQ-033 Timeout in HUNT SHALL only clear the ones count.
REQ-034 Supported timing: mdc half-period >= 4 clk. Back-to-back frames with no idle between them SHALL be accepted.
REQ-035 reg_addr and reg_wdata SHALL hold their values until overwritten by the next frame.

Reset
REQ-036 On rst_n=0 at posedge clk, these SHALL be 0 on the next cycle: state=HUNT, counters, mdio_out, mdio_en, reg_rd, reg_we, frame_err, reg_addr, reg_wdata, and the synchronizers.
REQ-037 Reset mid-read SHALL release MDIO (mdio_en=0) on the next clk.
REQ-038 After reset, a new frame SHALL require a full PRE_MIN-bit preamble.

Verification
REQ-039 Write frame to PHY_ADDR=1, reg 0x1F, data 0xA5C3 (PRE_MIN=32, half-period 96 clk) -> exactly one reg_we, reg_addr=0x1F, reg_wdata=0xA5C3, mdio_en never 1.
REQ-040 Read from reg 0x02 with reg_rdata=0x1234 -> one reg_rd; mdio_en high from TA bit 2 through data bit 0; the station samples 0 then 0x1234 MSB first; mdio_en=0 after one more fall.
REQ-041 Read to PHYAD 3 while PHY_ADDR=1 -> no reg_rd, mdio_en stays 0, and the next valid frame is decoded correctly.
REQ-042 Preamble of 31 ones then 01 -> frame ignored; a 32-one preamble then decodes.
REQ-043 Write frame with TA=11 -> frame_err pulse, no reg_we.
REQ-044 MDC stops for TIMEOUT+1 clk mid-RDATA -> mdio_en=0 and one frame_err pulse.
REQ-045 rst_n asserted mid-RDATA -> mdio_en=0 on the next clk; a full following frame is served correctly.
